delay_meter: RTL and testbench

//  Measures, in clk cycles, the interval between a start event and a stop event.

---
 rtl/delay_meter.sv | 150 +++++++++++++++
 tb/tb_delay_meter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_meter.sv
// delay_meter: measures the cycle count between a start event and a stop event
// and delivers each result through a valid/ready handshake.
// Optional build macro DELAY_METER_STATS_EN adds min/max/average statistics on
// accepted results (ports stats_clr_i, min_o, max_o, avg2_o).
module delay_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [CNT_W-1:0] delay_o,
  output logic             delay_valid_o,
  input  logic             delay_ready_i,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             missed_o
`ifdef DELAY_METER_STATS_EN
  ,
  input  logic             stats_clr_i,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic [CNT_W-1:0] avg2_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             ovf_q, ovf_d;
  logic             missed_q, missed_d;
  logic             xfer;

  // A result leaves the block on the cycle the consumer is ready while we hold it.
  assign xfer = (state_q == HOLD) && delay_ready_i;

  // Next-state and next-value decode for the measurement FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    ovf_d    = ovf_q;
    missed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && stop_i) begin
          // Start and stop on the same edge is a genuine zero-cycle interval.
          state_d = HOLD;
          delay_d = '0;
          ovf_d   = 1'b0;
        end else if (start_i) begin
          state_d = RUN;
          cnt_d   = CNT_ONE;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        if (stop_i) begin
          // Stop wins over a coincident start; cnt already equals the interval.
          state_d = HOLD;
          delay_d = cnt_q;
          ovf_d   = (cnt_q == CNT_MAX);
        end else if (start_i) begin
          cnt_d = CNT_ONE;
        end
      end
      HOLD: begin
        if (xfer) begin
          if (start_i) begin
            state_d = RUN;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else if (start_i) begin
          // No room for a new measurement while the result is still pending.
          missed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      delay_q  <= '0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
    end
  end

  assign delay_o       = delay_q;
  assign overflow_o    = ovf_q;
  assign missed_o      = missed_q;
  assign delay_valid_o = (state_q == HOLD);
  assign busy_o        = (state_q == RUN);

`ifdef DELAY_METER_STATS_EN
  logic [CNT_W-1:0] min_q, max_q, avg_q, prev_q;
  logic             first_q;
  logic [CNT_W:0]   pair_sum;

  // One extra bit keeps the sum of two maximal delays from wrapping.
  assign pair_sum = {1'b0, prev_q} + {1'b0, delay_q};

  // Statistics over accepted results; a clear beats a coincident transfer.
  always_ff @(posedge clk) begin
    if (rst || stats_clr_i) begin
      min_q   <= CNT_MAX;
      max_q   <= '0;
      avg_q   <= '0;
      prev_q  <= '0;
      first_q <= 1'b1;
    end else if (xfer) begin
      if (delay_q < min_q) min_q <= delay_q;
      if (delay_q > max_q) max_q <= delay_q;
      avg_q   <= first_q ? delay_q : pair_sum[CNT_W:1];
      prev_q  <= delay_q;
      first_q <= 1'b0;
    end
  end

  assign min_o  = min_q;
  assign max_o  = max_q;
  assign avg2_o = avg_q;
`endif

endmodule

// File: tb/tb_delay_meter.sv
// Self-checking bench for delay_meter: directed scenarios followed by random
// traffic, compared against a timestamp-based reference model. Two instances
// (CNT_W=16 and CNT_W=4) share stimulus so saturation is exercised as well.
module tb_delay_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, ready, clr;
  logic [15:0] delay16;
  logic [3:0]  delay4;
  logic        valid16, valid4, ovf16, ovf4, busy16, busy4, missed16, missed4;
`ifdef DELAY_METER_STATS_EN
  logic [15:0] min16, max16, avg16;
  logic [3:0]  min4, max4, avg4;
`endif

  delay_meter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .delay_o(delay16), .delay_valid_o(valid16), .delay_ready_i(ready),
    .overflow_o(ovf16), .busy_o(busy16), .missed_o(missed16)
`ifdef DELAY_METER_STATS_EN
    , .stats_clr_i(clr), .min_o(min16), .max_o(max16), .avg2_o(avg16)
`endif
  );

  delay_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .delay_o(delay4), .delay_valid_o(valid4), .delay_ready_i(ready),
    .overflow_o(ovf4), .busy_o(busy4), .missed_o(missed4)
`ifdef DELAY_METER_STATS_EN
    , .stats_clr_i(clr), .min_o(min4), .max_o(max4), .avg2_o(avg4)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: index 0 is the 16-bit instance, index 1 the 4-bit one.
  int cyc = 0;
  int maxv[2] = '{65535, 15};
  bit meas[2], hold[2], movf[2], mmissed[2];
  int t0[2], mdelay[2];
  int smin, smax, savg, sprev;
  bit sfirst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied at that edge.
  task automatic model_step(input bit s, input bit p, input bit r, input bit c, input bit rs);
    bit hs;
    int dv;
    int k;
    hs = !rs && hold[0] && r;
    dv = mdelay[0];
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        meas[i] = 0; hold[i] = 0; mdelay[i] = 0; movf[i] = 0; mmissed[i] = 0;
      end else begin
        mmissed[i] = hold[i] && s && !r;
        if (hold[i]) begin
          if (r) begin
            hold[i] = 0;
            if (s) begin meas[i] = 1; t0[i] = cyc; end
          end
        end else if (meas[i]) begin
          if (p) begin
            k = cyc - t0[i];
            mdelay[i] = (k > maxv[i]) ? maxv[i] : k;
            movf[i]   = (k >= maxv[i]);
            hold[i] = 1; meas[i] = 0;
          end else if (s) begin
            t0[i] = cyc;
          end
        end else if (s) begin
          if (p) begin hold[i] = 1; mdelay[i] = 0; movf[i] = 0; end
          else begin meas[i] = 1; t0[i] = cyc; end
        end
      end
    end
    if (rs || c) begin
      smin = 65535; smax = 0; savg = 0; sprev = 0; sfirst = 1;
    end else if (hs) begin
      if (dv < smin) smin = dv;
      if (dv > smax) smax = dv;
      savg  = sfirst ? dv : (sprev + dv) / 2;
      sprev = dv;
      sfirst = 0;
    end
    cyc++;
  endtask

  // Apply one cycle of stimulus, clock it, then compare both instances to the model.
  task automatic cycle(input bit s, input bit p, input bit r, input bit c, input bit rs);
    start = s; stop = p; ready = r; clr = c; rst = rs;
    @(posedge clk);
    model_step(s, p, r, c, rs);
    #1;
    check("busy16",   busy16,   meas[0]);
    check("valid16",  valid16,  hold[0]);
    check("missed16", missed16, mmissed[0]);
    check("busy4",    busy4,    meas[1]);
    check("valid4",   valid4,   hold[1]);
    check("missed4",  missed4,  mmissed[1]);
    if (hold[0]) begin
      check("delay16", delay16, mdelay[0]);
      check("ovf16",   ovf16,   movf[0]);
    end
    if (hold[1]) begin
      check("delay4", delay4, mdelay[1]);
      check("ovf4",   ovf4,   movf[1]);
    end
`ifdef DELAY_METER_STATS_EN
    check("min16", min16, smin);
    check("max16", max16, smax);
    check("avg16", avg16, savg);
`endif
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(0, 0, r, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int misses;
    start = 0; stop = 0; ready = 0; clr = 0; rst = 1;

    // Reset state.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("rst_delay16", delay16, 0);
    check("rst_ovf16", ovf16, 0);
    check("rst_valid16", valid16, 0);
    check("rst_busy16", busy16, 0);

    // Start, stop ten edges later, consumer always ready.
    cycle(1, 0, 1, 0, 0);
    idle(9, 1);
    cycle(0, 1, 1, 0, 0);
    check("t1_delay", delay16, 10);
    check("t1_valid", valid16, 1);
    check("t1_ovf", ovf16, 0);
    idle(1, 1);
    check("t1_valid_drop", valid16, 0);

    // Zero-delay event, then a lone stop that must produce nothing.
    cycle(1, 1, 1, 0, 0);
    check("t2_zero_delay", delay16, 0);
    check("t2_zero_valid", valid16, 1);
    idle(1, 1);
    cycle(0, 1, 1, 0, 0);
    check("t2_stop_alone", valid16, 0);

    // Twenty-cycle interval saturates the 4-bit instance.
    cycle(1, 0, 1, 0, 0);
    idle(19, 1);
    cycle(0, 1, 1, 0, 0);
    check("t3_delay16", delay16, 20);
    check("t3_delay4", delay4, 15);
    check("t3_ovf4", ovf4, 1);
    idle(1, 1);

    // Back-pressure: result held, start during hold dropped, start at transfer runs.
    cycle(1, 0, 0, 0, 0);
    idle(3, 0);
    cycle(0, 1, 0, 0, 0);
    misses = 0;
    cycle(0, 0, 0, 0, 0); misses += int'(missed16);
    cycle(1, 0, 0, 0, 0); misses += int'(missed16);
    check("t4_hold_delay", delay16, 4);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      misses += int'(missed16);
      check("t4_stable", delay16, 4);
    end
    check("t4_miss_count", misses, 1);
    cycle(1, 0, 1, 0, 0);
    check("t4_restart_busy", busy16, 1);
    check("t4_restart_valid", valid16, 0);
    cycle(0, 1, 1, 0, 0);
    idle(1, 1);

    // Reset mid-measurement discards it.
    cycle(1, 0, 1, 0, 0);
    idle(6, 1);
    cycle(0, 0, 1, 0, 1);
    check("t5_busy", busy16, 0);
    check("t5_valid", valid16, 0);
    cycle(0, 1, 1, 0, 0);
    check("t5_no_result", valid16, 0);

    // Statistics over accepted delays 10, 4, 13, then clear.
    cycle(0, 0, 1, 1, 0);
    cycle(1, 0, 1, 0, 0); idle(9, 1);  cycle(0, 1, 1, 0, 0); idle(1, 1);
`ifdef DELAY_METER_STATS_EN
    check("t6_avg_a", avg16, 10);
`endif
    cycle(1, 0, 1, 0, 0); idle(3, 1);  cycle(0, 1, 1, 0, 0); idle(1, 1);
`ifdef DELAY_METER_STATS_EN
    check("t6_avg_b", avg16, 7);
`endif
    cycle(1, 0, 1, 0, 0); idle(12, 1); cycle(0, 1, 1, 0, 0); idle(1, 1);
`ifdef DELAY_METER_STATS_EN
    check("t6_avg_c", avg16, 8);
    check("t6_min", min16, 4);
    check("t6_max", max16, 13);
`endif
    cycle(0, 0, 1, 1, 0);
`ifdef DELAY_METER_STATS_EN
    check("t6_clr_min", min16, 16'hFFFF);
    check("t6_clr_max", max16, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 6) == 0, ($urandom % 9) == 0, ($urandom % 2) == 0,
            ($urandom % 97) == 0, ($urandom % 211) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
